core_lsu_rport_mp: RTL and testbench

CORE_LSU_RPORT_MP -- requirements
Module: core_lsu_rport_mp

---
 rtl/lsu_pkg.sv | 55 +++++
 rtl/core_lsu_snoop_buf.sv | 62 ++++++
 rtl/core_lsu_rport_mp.sv | 217 +++++++++++++++++++++
 tb/tb_core_lsu_rport_mp.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: cache-op codes, load formats, tag layout and
// address-split / load-format helpers used by the read port.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_READ         = 3'd0,
    OP_DIRECT_INV   = 3'd1,
    OP_DIRECT_INVWB = 3'd2,
    OP_HIT_INV      = 3'd3
  } lsu_op_e;

  // bit 2 = zero-extend, bits [1:0] = size (0 byte, 1 half, 2 word)
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic [19:0] ptag;
  } tag_t;

  typedef struct packed {
    logic [19:0] ptag;
    logic [7:0]  idx;
    logic [3:0]  off;
  } addr_split_t;

  typedef enum logic [2:0] {
    ST_NORMAL,
    ST_UNC_READ,
    ST_REFILL,
    ST_INVOP,
    ST_WAIT
  } rport_state_e;

  function automatic addr_split_t split_addr(input logic [31:0] a);
    return '{ptag: a[31:12], idx: a[11:4], off: a[3:0]};
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] typ);
    logic [15:0] sh;
    logic [31:0] r;
    sh = 16'(w >> {off, 3'b000});
    case (typ[1:0])
      2'd0:    r = {{24{sh[7] & ~typ[2]}}, sh[7:0]};
      2'd1:    r = {{16{sh[15] & ~typ[2]}}, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_lsu_snoop_buf.sv
// Short history of write beats used to patch stale RAM read data that was
// captured before (or held across) later writes to the same word.
module core_lsu_snoop_buf #(
  parameter int WAY_CNT = 2,
  parameter int WADDR_W = 10,
  parameter int DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WAY_CNT*4-1:0]      wr_we,
  input  logic [WADDR_W-1:0]        wr_waddr,
  input  logic [31:0]               wr_wdata,
  input  logic [WADDR_W-1:0]        look_addr,
  input  logic [WAY_CNT-1:0][31:0]  data_in,
  output logic [WAY_CNT-1:0][31:0]  data_out
);
  import lsu_pkg::*;

  typedef logic [WAY_CNT-1:0][31:0] words_t;

  typedef struct packed {
    logic                 vld;
    logic [WAY_CNT*4-1:0] we;
    logic [WADDR_W-1:0]   addr;
    logic [31:0]          data;
  } beat_t;

  beat_t [DEPTH-1:0] ent;   // ent[0] is the newest beat
  beat_t             live;

  assign live = '{vld: |wr_we, we: wr_we, addr: wr_waddr, data: wr_wdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i].vld <= 1'b0;
    end else if (live.vld) begin
      ent[0] <= live;
      for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
    end
  end

  function automatic words_t apply(input words_t d, input logic [WAY_CNT*4-1:0] we,
                                   input logic [31:0] wd);
    words_t r;
    r = d;
    for (int w = 0; w < WAY_CNT; w++)
      for (int b = 0; b < 4; b++)
        if (we[w*4+b]) r[w][b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Oldest first so newer beats, and finally the live write, win per byte.
  always_comb begin
    data_out = data_in;
    for (int i = DEPTH-1; i >= 0; i--)
      if (ent[i].vld && ent[i].addr == look_addr)
        data_out = apply(data_out, ent[i].we, ent[i].data);
    if (live.vld && live.addr == look_addr)
      data_out = apply(data_out, live.we, live.data);
  end

endmodule

// File: rtl/core_lsu_rport_mp.sv
// Multi-way LSU read port: EX RAM read, M1 hit/snoop patch, M2 format and
// a small miss/uncached/cache-op FSM talking to the write port.
module core_lsu_rport_mp #(
  parameter int WAY_CNT     = 2,
  parameter int DIDX_LEN    = 12,
  parameter int SNOOP_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             ex_vaddr_i,
  input  logic [31:0]             m1_vaddr_i,
  input  logic [31:0]             m1_paddr_i,
  input  logic                    m1_uncached_i,
  input  logic                    m1_stall_i,
  input  logic [31:0]             m2_vaddr_i,
  input  logic [31:0]             m2_paddr_i,
  input  logic                    m2_valid_i,
  input  logic                    m2_uncached_i,
  input  logic                    m2_stall_i,
  input  logic [2:0]              m2_op_i,
  input  logic [2:0]              m2_type_i,
  output logic                    m2_busy_o,
  output logic [31:0]             m2_rdata_o,
  output logic                    m2_rvalid_o,
  output logic [WAY_CNT-1:0]      m2_hit_o,
  input  logic [WAY_CNT*4-1:0]    wr_data_we_i,
  input  logic [DIDX_LEN-3:0]     wr_data_waddr_i,
  input  logic [31:0]             wr_data_wdata_i,
  input  logic [WAY_CNT-1:0]      wr_tag_we_i,
  input  logic [7:0]              wr_tag_waddr_i,
  input  logic [20:0]             wr_tag_wdata_i,
  input  logic                    ws_read_ready_i,
  input  logic                    ws_uop_ready_i,
  input  logic [31:0]             ws_rdata_i,
  output logic                    req_refill_o,
  output logic                    req_uncached_read_o,
  output logic                    req_inv_o,
  output logic                    req_invwb_o,
  output logic [31:0]             req_addr_o
);
  import lsu_pkg::*;

  localparam int WADDR_W   = DIDX_LEN - 2;
  localparam int RAM_DEPTH = 1 << WADDR_W;
  localparam int WAY_W     = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;

  addr_split_t ex_sp, m1_sp, m2_sp, m1_psp, m2_psp;
  logic [WADDR_W-1:0] ex_word, m1_word, m2_word;

  assign ex_sp   = split_addr(ex_vaddr_i);
  assign m1_sp   = split_addr(m1_vaddr_i);
  assign m2_sp   = split_addr(m2_vaddr_i);
  assign m1_psp  = split_addr(m1_paddr_i);
  assign m2_psp  = split_addr(m2_paddr_i);
  assign ex_word = ex_vaddr_i[DIDX_LEN-1:2];
  assign m1_word = m1_vaddr_i[DIDX_LEN-1:2];
  assign m2_word = m2_vaddr_i[DIDX_LEN-1:2];

  logic [WAY_CNT-1:0][31:0] m1_rd, m1_data, m2_data;
  logic [WAY_CNT-1:0]       m1_hit, m2_hit;
  tag_t [WAY_CNT-1:0]       m1_tag;

  // ---------------- per-way RAMs and M1 tag compare ----------------
  for (genvar w = 0; w < WAY_CNT; w++) begin : g_way
    logic [31:0] dmem [RAM_DEPTH];
    tag_t        tmem [256];
    logic [31:0] rd_q;
    tag_t        tag_q;
    logic        tag_wr;

    assign tag_wr = wr_tag_we_i[w];

    always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
        if (wr_data_we_i[w*4+b]) dmem[wr_data_waddr_i][b*8 +: 8] <= wr_data_wdata_i[b*8 +: 8];
      if (!m1_stall_i) rd_q <= dmem[ex_word];
    end

    // Tag writes bypass into the read register so M1 never sees a stale tag.
    always_ff @(posedge clk) begin
      if (tag_wr) tmem[wr_tag_waddr_i] <= tag_t'(wr_tag_wdata_i);
      if (!m1_stall_i)
        tag_q <= (tag_wr && wr_tag_waddr_i == ex_sp.idx) ? tag_t'(wr_tag_wdata_i) : tmem[ex_sp.idx];
      else if (tag_wr && wr_tag_waddr_i == m1_sp.idx)
        tag_q <= tag_t'(wr_tag_wdata_i);
    end

    assign m1_rd[w]  = rd_q;
    assign m1_tag[w] = (tag_wr && wr_tag_waddr_i == m1_sp.idx) ? tag_t'(wr_tag_wdata_i) : tag_q;
    assign m1_hit[w] = m1_tag[w].valid && m1_tag[w].ptag == m1_psp.ptag && !m1_uncached_i;
  end

  core_lsu_snoop_buf #(
    .WAY_CNT (WAY_CNT),
    .WADDR_W (WADDR_W),
    .DEPTH   (SNOOP_DEPTH)
  ) u_snoop (
    .clk       (clk),
    .rst       (rst),
    .wr_we     (wr_data_we_i),
    .wr_waddr  (wr_data_waddr_i),
    .wr_wdata  (wr_data_wdata_i),
    .look_addr (m1_word),
    .data_in   (m1_rd),
    .data_out  (m1_data)
  );

  // ---------------- M2 stage registers ----------------
  // While held, the M2 hit is re-derived from any tag write to its index,
  // which is how a refill makes the stalled access hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      m2_hit  <= '0;
      m2_data <= '0;
    end else if (!m2_stall_i) begin
      m2_hit  <= m1_hit;
      m2_data <= m1_data;
    end else begin
      for (int w = 0; w < WAY_CNT; w++) begin
        if (wr_tag_we_i[w] && wr_tag_waddr_i == m2_sp.idx)
          m2_hit[w] <= wr_tag_wdata_i[20] && wr_tag_wdata_i[19:0] == m2_psp.ptag && !m2_uncached_i;
        for (int b = 0; b < 4; b++)
          if (wr_data_we_i[w*4+b] && wr_data_waddr_i == m2_word)
            m2_data[w][b*8 +: 8] <= wr_data_wdata_i[b*8 +: 8];
      end
    end
  end

  logic [31:0]      sel_word;
  logic [WAY_W-1:0] hit_idx;

  always_comb begin
    sel_word = '0;
    hit_idx  = '0;
    for (int w = 0; w < WAY_CNT; w++)
      if (m2_hit[w]) begin
        sel_word = sel_word | m2_data[w];
        hit_idx  = WAY_W'(w);
      end
  end

  // ---------------- miss / cache-op FSM ----------------
  rport_state_e state_q, state_d;
  logic         is_read, invwb_q;
  logic [31:0]  cap_q;

  assign is_read = (lsu_op_e'(m2_op_i) == OP_READ);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_NORMAL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL:
        if (m2_valid_i) begin
          if (is_read) begin
            if (m2_uncached_i)  state_d = ST_UNC_READ;
            else if (~|m2_hit)  state_d = ST_REFILL;
          end else if (!m2_uncached_i) begin
            state_d = ST_INVOP;
          end
        end
      ST_UNC_READ, ST_REFILL: if (ws_read_ready_i) state_d = ST_WAIT;
      ST_INVOP:               if (ws_uop_ready_i)  state_d = ST_WAIT;
      ST_WAIT:                if (!m2_stall_i)     state_d = ST_NORMAL;
      default:                state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    m2_busy_o           = 1'b0;
    req_refill_o        = 1'b0;
    req_uncached_read_o = 1'b0;
    req_inv_o           = 1'b0;
    req_invwb_o         = 1'b0;
    case (state_q)
      ST_NORMAL:   m2_busy_o = (state_d != ST_NORMAL);
      ST_UNC_READ: begin m2_busy_o = 1'b1; req_uncached_read_o = 1'b1; end
      ST_REFILL:   begin m2_busy_o = 1'b1; req_refill_o = 1'b1; end
      ST_INVOP:    begin m2_busy_o = 1'b1; req_inv_o = !invwb_q; req_invwb_o = invwb_q; end
      default:     ;
    endcase
  end

  // Latched at departure so the request level cannot flicker mid-operation.
  always_ff @(posedge clk) begin
    if (rst)
      invwb_q <= 1'b0;
    else if (state_q == ST_NORMAL && state_d == ST_INVOP)
      invwb_q <= (lsu_op_e'(m2_op_i) != OP_DIRECT_INV);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cap_q <= '0;
    else if ((state_q == ST_UNC_READ || state_q == ST_REFILL) && ws_read_ready_i)
      cap_q <= ws_rdata_i;
    else if (state_q == ST_NORMAL || (state_q == ST_WAIT && !m2_stall_i))
      cap_q <= '0;
  end

  assign m2_rdata_o  = fmt_load(cap_q | sel_word, m2_vaddr_i[1:0], m2_type_i);
  assign m2_rvalid_o = m2_valid_i && is_read && !m2_busy_o;
  assign m2_hit_o    = m2_hit;

  always_comb begin
    req_addr_o = m2_paddr_i;
    if (WAY_CNT > 1 && lsu_op_e'(m2_op_i) == OP_HIT_INV) req_addr_o[WAY_W-1:0] = hit_idx;
  end

  logic unused_ok;
  assign unused_ok = ^{ex_sp, m1_sp, m2_sp, m1_psp, m2_psp, ex_vaddr_i, m1_vaddr_i, m2_vaddr_i};

endmodule

// File: tb/tb_core_lsu_rport_mp.sv
// Directed bench for core_lsu_rport_mp (4 ways, 3-deep snoop buffer).
module tb_core_lsu_rport_mp;
  import lsu_pkg::*;

  localparam int WAY_CNT = 4;
  localparam int DIDX_LEN = 12;

  logic clk = 1'b0, rst;
  logic [31:0] ex_vaddr, m1_vaddr, m1_paddr, m2_vaddr, m2_paddr;
  logic m1_uncached, m1_stall, m2_valid, m2_uncached, m2_stall;
  logic [2:0] m2_op, m2_type;
  logic m2_busy, m2_rvalid;
  logic [31:0] m2_rdata;
  logic [WAY_CNT-1:0] m2_hit;
  logic [WAY_CNT*4-1:0] wr_data_we;
  logic [DIDX_LEN-3:0] wr_data_waddr;
  logic [31:0] wr_data_wdata;
  logic [WAY_CNT-1:0] wr_tag_we;
  logic [7:0] wr_tag_waddr;
  logic [20:0] wr_tag_wdata;
  logic ws_read_ready, ws_uop_ready;
  logic [31:0] ws_rdata;
  logic req_refill, req_uncached_read, req_inv, req_invwb;
  logic [31:0] req_addr;

  int checks = 0, errors = 0, busy_cycles;

  core_lsu_rport_mp #(.WAY_CNT(WAY_CNT), .DIDX_LEN(DIDX_LEN), .SNOOP_DEPTH(3)) dut (
    .clk(clk), .rst(rst),
    .ex_vaddr_i(ex_vaddr), .m1_vaddr_i(m1_vaddr), .m1_paddr_i(m1_paddr),
    .m1_uncached_i(m1_uncached), .m1_stall_i(m1_stall),
    .m2_vaddr_i(m2_vaddr), .m2_paddr_i(m2_paddr), .m2_valid_i(m2_valid),
    .m2_uncached_i(m2_uncached), .m2_stall_i(m2_stall), .m2_op_i(m2_op), .m2_type_i(m2_type),
    .m2_busy_o(m2_busy), .m2_rdata_o(m2_rdata), .m2_rvalid_o(m2_rvalid), .m2_hit_o(m2_hit),
    .wr_data_we_i(wr_data_we), .wr_data_waddr_i(wr_data_waddr), .wr_data_wdata_i(wr_data_wdata),
    .wr_tag_we_i(wr_tag_we), .wr_tag_waddr_i(wr_tag_waddr), .wr_tag_wdata_i(wr_tag_wdata),
    .ws_read_ready_i(ws_read_ready), .ws_uop_ready_i(ws_uop_ready), .ws_rdata_i(ws_rdata),
    .req_refill_o(req_refill), .req_uncached_read_o(req_uncached_read),
    .req_inv_o(req_inv), .req_invwb_o(req_invwb), .req_addr_o(req_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  off;
    logic [2:0]  typ;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  task automatic wr_tag(input logic [7:0] idx, input logic [3:0] ways, input logic v,
                        input logic [19:0] pt);
    wr_tag_we = ways; wr_tag_waddr = idx; wr_tag_wdata = {v, pt};
    tick();
    wr_tag_we = '0;
  endtask

  task automatic wr_data(input logic [9:0] wa, input logic [15:0] we, input logic [31:0] d);
    wr_data_we = we; wr_data_waddr = wa; wr_data_wdata = d;
    tick();
    wr_data_we = '0;
  endtask

  task automatic set_addr(input logic [31:0] va, input logic [31:0] pa, input logic unc);
    ex_vaddr = va; m1_vaddr = va; m2_vaddr = va;
    m1_paddr = pa; m2_paddr = pa;
    m1_uncached = unc; m2_uncached = unc;
  endtask

  // Run the address through EX and M1 so M2 holds its RAM/hit results.
  task automatic prime(input logic [31:0] va, input logic [31:0] pa, input logic unc);
    set_addr(va, pa, unc);
    m2_valid = 1'b0; m1_stall = 1'b0; m2_stall = 1'b0;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1;
    set_addr(32'h0, 32'h0, 1'b0);
    m1_stall = 0; m2_valid = 0; m2_stall = 0; m2_op = OP_READ; m2_type = LT_LW;
    wr_data_we = '0; wr_data_waddr = '0; wr_data_wdata = '0;
    wr_tag_we = '0; wr_tag_waddr = '0; wr_tag_wdata = '0;
    ws_read_ready = 0; ws_uop_ready = 0; ws_rdata = '0;

    vecs[0] = '{2'd2, LT_LB,  32'hFFFFFFBB};
    vecs[1] = '{2'd2, LT_LBU, 32'h000000BB};
    vecs[2] = '{2'd0, LT_LB,  32'hFFFFFFDD};
    vecs[3] = '{2'd3, LT_LBU, 32'h000000AA};
    vecs[4] = '{2'd0, LT_LH,  32'hFFFFCCDD};
    vecs[5] = '{2'd2, LT_LHU, 32'h0000AABB};
    vecs[6] = '{2'd2, LT_LH,  32'hFFFFAABB};
    vecs[7] = '{2'd0, LT_LW,  32'hAABBCCDD};

    tick(); tick();
    chk("rst busy", {31'd0, m2_busy}, 0);
    chk("rst rvalid", {31'd0, m2_rvalid}, 0);
    chk("rst rdata", m2_rdata, 0);
    chk("rst hit", {28'd0, m2_hit}, 0);
    chk("rst reqs", {28'd0, req_refill, req_uncached_read, req_inv, req_invwb}, 0);
    chk("rst req_addr", req_addr, 0);
    rst = 1'b0;

    // Hit loads: tag 0x12345 in way 1, word 0xAABBCCDD at 0x120.
    wr_tag(8'h12, 4'hF, 1'b0, 20'h0);
    wr_tag(8'h12, 4'b0010, 1'b1, 20'h12345);
    wr_data(10'h048, 16'h00F0, 32'hAABBCCDD);
    for (int i = 0; i < 8; i++) begin
      prime(32'h0000_0120 | {30'd0, vecs[i].off}, 32'h1234_5120 | {30'd0, vecs[i].off}, 1'b0);
      m2_valid = 1'b1; m2_op = OP_READ; m2_type = vecs[i].typ;
      #1;
      chk($sformatf("hit rdata v%0d", i), m2_rdata, vecs[i].exp);
      chk($sformatf("hit way v%0d", i), {28'd0, m2_hit}, 32'h2);
      chk($sformatf("hit busy v%0d", i), {31'd0, m2_busy}, 0);
      chk($sformatf("hit rvalid v%0d", i), {31'd0, m2_rvalid}, 1);
    end

    // Cached miss -> refill.
    wr_tag(8'h34, 4'hF, 1'b0, 20'h0);
    prime(32'h0000_0340, 32'h00AB_C340, 1'b0);
    m2_valid = 1'b1; m2_op = OP_READ; m2_type = LT_LW;
    #1;
    busy_cycles = 0;
    chk("miss depart busy", {31'd0, m2_busy}, 1);
    chk("miss depart refill", {31'd0, req_refill}, 0);
    if (m2_busy) busy_cycles++;
    m2_stall = 1'b1; m1_stall = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin ws_read_ready = 1'b1; ws_rdata = 32'h11223344; end
      #1;
      chk($sformatf("refill req c%0d", c), {31'd0, req_refill}, 1);
      if (m2_busy) busy_cycles++;
    end
    tick();
    ws_read_ready = 1'b0; m2_stall = 1'b0; m1_stall = 1'b0;
    #1;
    chk("miss busy cycles", busy_cycles, 4);
    chk("miss wait busy", {31'd0, m2_busy}, 0);
    chk("miss wait refill", {31'd0, req_refill}, 0);
    chk("miss rvalid", {31'd0, m2_rvalid}, 1);
    chk("miss rdata", m2_rdata, 32'h11223344);
    m2_valid = 1'b0;
    tick(); #1;
    chk("capture cleared", m2_rdata, 0);

    // Snoop: M1 read of 0x560 held while DEADBEEF and two more writes land.
    wr_tag(8'h56, 4'hF, 1'b0, 20'h0);
    wr_tag(8'h56, 4'b0001, 1'b1, 20'h00555);
    wr_data(10'h158, 16'h000F, 32'h01010101);
    for (int i = 0; i < 3; i++) wr_data(10'h3F0, 16'h0F00, 32'h0 + i);
    set_addr(32'h0000_0560, 32'h0055_5560, 1'b0);
    m1_stall = 1'b0; m2_stall = 1'b1; m2_valid = 1'b0;
    tick();
    m1_stall = 1'b1;
    wr_data(10'h158, 16'h000F, 32'hDEADBEEF);
    wr_data(10'h3F1, 16'h0F00, 32'h12121212);
    wr_data(10'h3F2, 16'h0F00, 32'h34343434);
    m2_stall = 1'b0;
    tick();
    m2_valid = 1'b1; m2_op = OP_READ; m2_type = LT_LW;
    #1;
    chk("snoop rdata", m2_rdata, 32'hDEADBEEF);
    chk("snoop hit", {28'd0, m2_hit}, 32'h1);
    chk("snoop busy", {31'd0, m2_busy}, 0);
    m2_valid = 1'b0; m1_stall = 1'b0;

    // Uncached word load.
    prime(32'h0000_0780, 32'h1FC0_0780, 1'b1);
    m2_valid = 1'b1; m2_op = OP_READ; m2_type = LT_LW;
    #1;
    chk("unc depart busy", {31'd0, m2_busy}, 1);
    chk("unc hit", {28'd0, m2_hit}, 0);
    m2_stall = 1'b1;
    tick(); #1;
    chk("unc req c1", {31'd0, req_uncached_read}, 1);
    chk("unc rvalid c1", {31'd0, m2_rvalid}, 0);
    tick();
    ws_read_ready = 1'b1; ws_rdata = 32'hCAFEF00D;
    #1;
    chk("unc req c2", {31'd0, req_uncached_read}, 1);
    tick();
    ws_read_ready = 1'b0; m2_stall = 1'b0;
    #1;
    chk("unc rdata", m2_rdata, 32'hCAFEF00D);
    chk("unc rvalid", {31'd0, m2_rvalid}, 1);
    chk("unc req off", {31'd0, req_uncached_read}, 0);
    m2_valid = 1'b0;
    tick();

    // HIT_INV on way 3.
    wr_tag(8'h9A, 4'hF, 1'b0, 20'h0);
    wr_tag(8'h9A, 4'b1000, 1'b1, 20'h0BEEF);
    prime(32'h0000_09A0, 32'h0BEE_F9A0, 1'b0);
    m2_valid = 1'b1; m2_op = OP_HIT_INV;
    #1;
    chk("hinv hit", {28'd0, m2_hit}, 32'h8);
    chk("hinv depart busy", {31'd0, m2_busy}, 1);
    chk("hinv rvalid", {31'd0, m2_rvalid}, 0);
    m2_stall = 1'b1;
    tick(); #1;
    chk("hinv invwb", {31'd0, req_invwb}, 1);
    chk("hinv inv", {31'd0, req_inv}, 0);
    chk("hinv addr", req_addr, 32'h0BEEF9A3);
    tick();
    ws_uop_ready = 1'b1;
    #1;
    chk("hinv busy at ready", {31'd0, m2_busy}, 1);
    tick();
    ws_uop_ready = 1'b0;
    #1;
    chk("hinv busy after", {31'd0, m2_busy}, 0);
    chk("hinv invwb off", {31'd0, req_invwb}, 0);
    m2_stall = 1'b0; m2_valid = 1'b0;
    tick();

    // DIRECT_INV asks for plain invalidate.
    prime(32'h0000_09A0, 32'h0BEE_F9A0, 1'b0);
    m2_valid = 1'b1; m2_op = OP_DIRECT_INV;
    m2_stall = 1'b1;
    tick(); #1;
    chk("dinv inv", {31'd0, req_inv}, 1);
    chk("dinv invwb", {31'd0, req_invwb}, 0);
    chk("dinv addr", req_addr, 32'h0BEEF9A0);
    ws_uop_ready = 1'b1;
    tick();
    ws_uop_ready = 1'b0; m2_stall = 1'b0; m2_valid = 1'b0;
    tick();

    // Reset in the middle of a refill, with ready arriving on the reset cycle.
    prime(32'h0000_0340, 32'h00AB_C340, 1'b0);
    m2_valid = 1'b1; m2_op = OP_READ; m2_type = LT_LW;
    m2_stall = 1'b1;
    tick(); tick(); #1;
    chk("pre-rst refill", {31'd0, req_refill}, 1);
    rst = 1'b1; ws_read_ready = 1'b1; ws_rdata = 32'h55555555; m2_valid = 1'b0;
    tick();
    rst = 1'b0; ws_read_ready = 1'b0;
    #1;
    chk("post-rst refill", {31'd0, req_refill}, 0);
    chk("post-rst busy", {31'd0, m2_busy}, 0);
    chk("post-rst rdata", m2_rdata, 0);
    chk("post-rst hit", {28'd0, m2_hit}, 0);
    m2_stall = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
